sram_stream_reader: RTL and testbench
=====================================

// Module: sram_stream_reader
// PURPOSE
// - Read-side master for the ccs_ram_sync_1R1W SRAM (1R1W, synchronous read).
// - Given a base address and a word count, drives the SRAM read port (re/radr).
// - Returns q as a valid/ready stream.
// - Credit-limited output FIFO absorbs downstream backpressure without losing in-flight reads.
// - Sits between the conv accelerator's buffer SRAMs and its datapath.
// PARAMETERS
// - DATA_WIDTH  128   SRAM word / stream width
// - ADDR_WIDTH  12    SRAM address width
// - DEPTH       4096  SRAM words; addresses wrap modulo DEPTH (need not be 2^n)
// - RD_LATENCY  1     cycles from re sampled to q valid
// - FIFO_DEPTH  4     output FIFO entries; must be >= RD_LATENCY+2
// PORTS
// - clk        in   1             clock, rising edge
// - rst_n      in   1             asynchronous active-low reset
// - start      in   1             request pulse; accepted only in IDLE
// - base_adr   in   ADDR_WIDTH    first address, sampled with start
// - len        in   ADDR_WIDTH+1  word count 0..DEPTH, sampled with start
// - busy       out  1             transfer in progress
// - done       out  1             1-cycle pulse at transfer completion
// - re         out  1             SRAM read enable
// - radr       out  ADDR_WIDTH    SRAM read address
// - q          in   DATA_WIDTH    SRAM read data
// - out_data   out  DATA_WIDTH    stream data
// - out_valid  out  1             stream valid
// - out_ready  in   1             stream ready
// BEHAVIOUR
// - Reset: all outputs 0 (busy, done, re, radr, out_valid, out_data).
//   - Clears the FIFO, in-flight counter and FSM to IDLE.
//   - Reset mid-transfer: reads still in flight are discarded; q is ignored afterwards.
// - FSM IDLE -> RUN -> DRAIN -> IDLE.
//   - IDLE: start=1 captures base_adr/len.
//     - len>0: go to RUN, busy=1 next cycle.
//     - len==0: no reads are issued; done pulses the next cycle and busy stays 0.
//   - RUN: re=1 whenever remaining>0 and fifo_count+inflight < FIFO_DEPTH.
//     - Each issue decrements remaining and advances radr by +1.
//     - radr wraps DEPTH-1 -> 0.
//     - The cycle the last read issues, go to DRAIN.
//   - DRAIN: re=0; wait until inflight==0 and the FIFO is empty.
//     - Then done=1 for one cycle, busy=0 in that same cycle, state -> IDLE.
// - start while busy is ignored; base_adr/len are not re-sampled.
// - Read timing: re is first high in the cycle after start is sampled.
//   - q is captured into the FIFO RD_LATENCY cycles after each re cycle.
//   - The FIFO is registered: first out_valid appears RD_LATENCY+1 cycles after the first re cycle.
// - Stream: a transfer occurs when out_valid && out_ready.
//   - out_data/out_valid hold stable while out_valid && !out_ready.
//   - Words are emitted in address-issue order.
// - Throughput: with out_ready held high, one word per cycle is sustained.
//   - Credit accounting counts a same-cycle pop as freed.
// - Credit: in-flight reads plus FIFO occupancy never exceed FIFO_DEPTH, so the FIFO never overflows.
//   - Underflow is impossible because out_valid = FIFO non-empty.
// - A push and a pop in the same cycle leave the FIFO count unchanged.
// - Counters: remaining is ADDR_WIDTH+1 bits; inflight is clog2(FIFO_DEPTH+1) bits.
// CONFIGURATION
// - SRAM_READER_STRIDE_EN defined:
//   - Adds input port stride [ADDR_WIDTH-1:0], sampled with start.
//   - radr advances by stride modulo DEPTH.
//   - stride==0 re-reads base_adr len times.
// - Not defined: the stride port is absent and the step is fixed at +1.
// TESTING
// - Reset, then start base_adr=0 len=1:
//   - re=1 radr=0 for exactly one cycle.
//   - out_valid 2 cycles later with the preloaded word.
//   - done pulses after the handshake.
// - len=8 base_adr=16, out_ready=1:
//   - 8 consecutive re cycles, radr=16..23.
//   - 8 back-to-back words in order.
//   - done one cycle after the last handshake.
// - base_adr=4094 len=4: radr sequence 4094,4095,0,1 with matching data.
// - len=16 with out_ready toggling 1-in-3:
//   - FIFO never exceeds 4 entries; out_data is stable while stalled.
//   - All 16 words arrive in order.
// - start with len=0 -> no re, done pulse next cycle.
// - start during busy -> ignored.
// - rst_n low mid-transfer -> all outputs 0, FSM IDLE.
// - STRIDE_EN, base_adr=0 stride=3 len=4 -> radr 0,3,6,9.

Source files
------------

// File: rtl/sram_stream_reader_if.sv
// Bundles the request, SRAM read-port and output-stream signals of sram_stream_reader.
// The stride signal exists only when SRAM_READER_STRIDE_EN is defined.
interface sram_stream_reader_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_adr;
    logic [ADDR_WIDTH:0]   len;
`ifdef SRAM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride;
`endif
    logic                  busy;
    logic                  done;
    logic                  re;
    logic [ADDR_WIDTH-1:0] radr;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Stream handshake: a word moves when out_valid && out_ready at the rising
    // edge; while out_valid && !out_ready, out_valid and out_data hold unchanged.
    modport master (
        input  start, base_adr, len, q, out_ready,
`ifdef SRAM_READER_STRIDE_EN
        input  stride,
`endif
        output busy, done, re, radr, out_data, out_valid
    );

    modport slave (
        output start, base_adr, len, q, out_ready,
`ifdef SRAM_READER_STRIDE_EN
        output stride,
`endif
        input  busy, done, re, radr, out_data, out_valid
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Read master for a 1R1W synchronous SRAM: issues len reads from base_adr and streams q
// through a credit-limited FIFO. Optional address stride via SRAM_READER_STRIDE_EN.
module sram_stream_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_stream_reader_if.master   bus,
    output logic [1:0]             state_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d, step_q, step_d;
    logic [ADDR_WIDTH:0]   adr_sum;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [CW-1:0]         infl_q, infl_d, cnt_q, cnt_d;
    logic [CW:0]           occ;
    logic [PW-1:0]         wr_q, rd_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  issue, push, pop, credit_ok, drained;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push      = pipe_q[RD_LATENCY-1];
    assign pop       = bus.out_valid && bus.out_ready;
    // A word popped this cycle frees its slot immediately, sustaining one word per cycle.
    assign occ       = {1'b0, cnt_q} + {1'b0, infl_q} - {{CW{1'b0}}, pop};
    assign credit_ok = occ < (CW+1)'(FIFO_DEPTH);
    assign issue     = (state_q == RUN) && (rem_q != '0) && credit_ok;
    assign drained   = (infl_q == '0) && (cnt_q == '0);
    assign state_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.len != '0) ? RUN : DRAIN;
            RUN:     if (issue && rem_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.re   = issue;
        bus.done = (state_q == DRAIN) && drained;
        bus.busy = (state_q == RUN) || ((state_q == DRAIN) && !drained);
    end

    // Address/step bookkeeping; the step is captured with start so it cannot change mid-burst.
    always_comb begin
        rem_d   = rem_q;
        adr_d   = adr_q;
        step_d  = step_q;
        adr_sum = {1'b0, adr_q} + {1'b0, step_q};
        if (adr_sum >= (ADDR_WIDTH+1)'(DEPTH)) adr_sum = adr_sum - (ADDR_WIDTH+1)'(DEPTH);
        if (state_q == IDLE && bus.start) begin
            rem_d  = bus.len;
            adr_d  = bus.base_adr;
`ifdef SRAM_READER_STRIDE_EN
            step_d = bus.stride;
`else
            step_d = ADDR_WIDTH'(1);
`endif
        end else if (issue) begin
            rem_d = rem_q - (ADDR_WIDTH+1)'(1);
            adr_d = adr_sum[ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = issue;
        infl_d    = infl_q;
        cnt_d     = cnt_q;
        if (issue && !push) infl_d = infl_q + CW'(1);
        if (!issue && push) infl_d = infl_q - CW'(1);
        if (push && !pop)   cnt_d  = cnt_q + CW'(1);
        if (!push && pop)   cnt_d  = cnt_q - CW'(1);
    end

    // Reset clears the latency pipe too, so reads in flight at reset never land in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            adr_q  <= '0;
            step_q <= '0;
            pipe_q <= '0;
            infl_q <= '0;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rem_q  <= rem_d;
            adr_q  <= adr_d;
            step_q <= step_d;
            pipe_q <= pipe_d;
            infl_q <= infl_d;
            cnt_q  <= cnt_d;
            if (push) begin
                mem_q[wr_q] <= bus.q;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
        end
    end

    assign bus.radr      = adr_q;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = mem_q[rd_q];
endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed self-checking bench for sram_stream_reader with a 1-cycle SRAM model
// and a negedge monitor collecting issued addresses, stream words and done pulses.
module tb_sram_stream_reader;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] state_o;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int ready_mode = 0;
  logic mon_clr = 0;

  sram_stream_reader_if #(.DATA_WIDTH(128), .ADDR_WIDTH(12)) bus ();

  sram_stream_reader #(.DATA_WIDTH(128), .ADDR_WIDTH(12), .DEPTH(4096),
                       .RD_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master), .state_o(state_o));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  function automatic logic [127:0] word(input logic [11:0] a);
    return {32'hA5A5_0000 | {20'h0, a}, ~{20'h0, a}, 32'h1234_5678, {20'h0, a}};
  endfunction

  // SRAM model, 1-cycle read latency
  always @(posedge clk) if (bus.re) bus.q <= word(bus.radr);

  // downstream ready: 0 = always ready, 1 = ready one cycle in three, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: bus.out_ready = (cyc % 3 == 0);
      2: bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // monitor / scoreboard capture
  logic [11:0]  re_adr_q[$];
  int           re_cyc_q[$];
  logic [127:0] out_q[$];
  int           out_cyc_q[$];
  int           done_cyc_q[$];
  int busy_cnt, max_out, stab_err;
  logic prev_stall;
  logic [127:0] prev_data;

  always @(negedge clk) begin
    if (mon_clr || !rst_n) begin
      if (mon_clr) begin
        re_adr_q.delete(); re_cyc_q.delete(); out_q.delete(); out_cyc_q.delete();
        done_cyc_q.delete(); busy_cnt = 0; max_out = 0; stab_err = 0;
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_err++;
      if (bus.re) begin re_adr_q.push_back(bus.radr); re_cyc_q.push_back(cyc); end
      if (bus.out_valid && bus.out_ready) begin out_q.push_back(bus.out_data); out_cyc_q.push_back(cyc); end
      if (bus.done) done_cyc_q.push_back(cyc);
      if (bus.busy) busy_cnt++;
      if (re_adr_q.size() - out_q.size() > max_out) max_out = re_adr_q.size() - out_q.size();
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // driver tasks
  task automatic clr_mon();
    @(posedge clk); #1; mon_clr = 1;
    @(posedge clk); #1; mon_clr = 0;
  endtask

  task automatic start_xfer(input logic [11:0] b, input logic [12:0] l, output int s);
    @(posedge clk); #1;
    bus.start = 1; bus.base_adr = b; bus.len = l; s = cyc;
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
    vectors++;
    if (done_cyc_q.size() == 0) begin
      miscompares++; $display("FAIL %s_timeout: got no done after %0d cycles, required a done pulse", name, n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    bus.start = 0; bus.base_adr = 0; bus.len = 0;
`ifdef SRAM_READER_STRIDE_EN
    bus.stride = 12'd1;
`endif
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({bus.busy, bus.done, bus.re, bus.out_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_flags: got %b required 0000", {bus.busy, bus.done, bus.re, bus.out_valid}); end
    vectors++; if (bus.radr !== 12'd0) begin miscompares++; $display("FAIL reset_radr: got %0d required 0", bus.radr); end
    vectors++; if (bus.out_data !== 128'd0) begin miscompares++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    rst_n = 1;
    @(negedge clk);
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d required 0", state_o); end
  endtask

  task automatic test_single();
    int s;
    clr_mon();
    start_xfer(12'd0, 13'd1, s);
    wait_done("single");
    vectors++; if (re_adr_q.size() != 1) begin miscompares++; $display("FAIL single_re_count: got %0d required 1", re_adr_q.size()); end
    vectors++; if (re_adr_q[0] !== 12'd0 || re_cyc_q[0] != s + 1) begin miscompares++; $display("FAIL single_re: got adr %0d cyc %0d required adr 0 cyc %0d", re_adr_q[0], re_cyc_q[0], s + 1); end
    vectors++; if (out_q.size() != 1 || out_q[0] !== word(12'd0)) begin miscompares++; $display("FAIL single_data: got n=%0d %h required n=1 %h", out_q.size(), out_q[0], word(12'd0)); end
    vectors++; if (out_cyc_q[0] != s + 3) begin miscompares++; $display("FAIL single_out_cyc: got %0d required %0d", out_cyc_q[0], s + 3); end
    vectors++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 4) begin miscompares++; $display("FAIL single_done: got n=%0d cyc %0d required n=1 cyc %0d", done_cyc_q.size(), done_cyc_q[0], s + 4); end
  endtask

  task automatic test_burst();
    int s;
    clr_mon();
    start_xfer(12'd16, 13'd8, s);
    wait_done("burst");
    vectors++; if (re_adr_q.size() != 8 || out_q.size() != 8) begin miscompares++; $display("FAIL burst_count: got re %0d out %0d required 8 8", re_adr_q.size(), out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (re_adr_q[i] !== 12'(16 + i) || re_cyc_q[i] != s + 1 + i) begin miscompares++; $display("FAIL burst_re[%0d]: got adr %0d cyc %0d required adr %0d cyc %0d", i, re_adr_q[i], re_cyc_q[i], 16 + i, s + 1 + i); end
      vectors++; if (out_q[i] !== word(12'(16 + i)) || out_cyc_q[i] != s + 3 + i) begin miscompares++; $display("FAIL burst_out[%0d]: got %h cyc %0d required %h cyc %0d", i, out_q[i], out_cyc_q[i], word(12'(16 + i)), s + 3 + i); end
    end
    vectors++; if (done_cyc_q[0] != s + 11) begin miscompares++; $display("FAIL burst_done: got cyc %0d required %0d", done_cyc_q[0], s + 11); end
  endtask

  task automatic test_wrap();
    int s;
    logic [11:0] exp_a [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    clr_mon();
    start_xfer(12'd4094, 13'd4, s);
    wait_done("wrap");
    vectors++; if (out_q.size() != 4) begin miscompares++; $display("FAIL wrap_count: got %0d required 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (re_adr_q[i] !== exp_a[i] || out_q[i] !== word(exp_a[i])) begin miscompares++; $display("FAIL wrap[%0d]: got adr %0d data %h required adr %0d data %h", i, re_adr_q[i], out_q[i], exp_a[i], word(exp_a[i])); end
    end
  endtask

  task automatic test_backpressure();
    int s;
    logic [127:0] exp_q[$];
    clr_mon();
    ready_mode = 1;
    for (int i = 0; i < 16; i++) exp_q.push_back(word(12'(100 + i)));
    start_xfer(12'd100, 13'd16, s);
    wait_done("bp");
    ready_mode = 0;
    vectors++; if (out_q.size() != 16) begin miscompares++; $display("FAIL bp_count: got %0d required 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (out_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %h required %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (max_out > 4) begin miscompares++; $display("FAIL bp_credit: got %0d outstanding required <= 4", max_out); end
    vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stab_err); end
  endtask

  task automatic test_len0();
    int s;
    clr_mon();
    start_xfer(12'd50, 13'd0, s);
    wait_done("len0");
    vectors++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != s + 1) begin miscompares++; $display("FAIL len0_done: got n=%0d cyc %0d required n=1 cyc %0d", done_cyc_q.size(), done_cyc_q[0], s + 1); end
    vectors++; if (re_adr_q.size() != 0 || busy_cnt != 0) begin miscompares++; $display("FAIL len0_idle: got re %0d busy %0d required 0 0", re_adr_q.size(), busy_cnt); end
  endtask

  task automatic test_start_busy();
    int s;
    clr_mon();
    start_xfer(12'd200, 13'd4, s);
    bus.start = 1; bus.base_adr = 12'd300; bus.len = 13'd2;
    @(posedge clk); #1;
    bus.start = 0;
    wait_done("busy_start");
    repeat (10) @(posedge clk);
    vectors++; if (re_adr_q.size() != 4 || out_q.size() != 4 || done_cyc_q.size() != 1) begin miscompares++; $display("FAIL busy_start_count: got re %0d out %0d done %0d required 4 4 1", re_adr_q.size(), out_q.size(), done_cyc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_q[i] !== word(12'(200 + i))) begin miscompares++; $display("FAIL busy_start_data[%0d]: got %h required %h", i, out_q[i], word(12'(200 + i))); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    clr_mon();
    ready_mode = 2;
    start_xfer(12'd500, 13'd16, s);
    repeat (3) @(posedge clk);
    #1; rst_n = 0;
    @(negedge clk);
    vectors++; if ({bus.busy, bus.done, bus.re, bus.out_valid} !== 4'b0 || bus.radr !== 12'd0 || bus.out_data !== 128'd0) begin miscompares++; $display("FAIL rstmid_outputs: got flags %b radr %0d data %h required all 0", {bus.busy, bus.done, bus.re, bus.out_valid}, bus.radr, bus.out_data); end
    vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL rstmid_state: got %0d required 0", state_o); end
    @(posedge clk); #1; rst_n = 1; ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({bus.busy, bus.re, bus.out_valid} !== 3'b0) begin miscompares++; $display("FAIL rstmid_quiet[%0d]: got %b required 000", i, {bus.busy, bus.re, bus.out_valid}); end
    end
    clr_mon();
    start_xfer(12'd7, 13'd1, s);
    wait_done("rstmid_after");
    vectors++; if (out_q.size() != 1 || out_q[0] !== word(12'd7)) begin miscompares++; $display("FAIL rstmid_after: got n=%0d %h required n=1 %h", out_q.size(), out_q[0], word(12'd7)); end
  endtask

`ifdef SRAM_READER_STRIDE_EN
  task automatic test_stride();
    int s;
    clr_mon();
    bus.stride = 12'd3;
    start_xfer(12'd0, 13'd4, s);
    wait_done("stride");
    bus.stride = 12'd1;
    vectors++; if (re_adr_q.size() != 4) begin miscompares++; $display("FAIL stride_count: got %0d required 4", re_adr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (re_adr_q[i] !== 12'(3 * i) || out_q[i] !== word(12'(3 * i))) begin miscompares++; $display("FAIL stride[%0d]: got adr %0d required %0d", i, re_adr_q[i], 3 * i); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_backpressure();
    test_len0();
    test_start_busy();
    test_reset_mid();
`ifdef SRAM_READER_STRIDE_EN
    test_stride();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
